chord_envelope: RTL and testbench

CHORD_ENVELOPE -- requirements
Module: chord_envelope

---
 rtl/chord_envelope.sv | 160 ++++++++++++++++
 tb/tb_chord_envelope.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chord_envelope.sv
// -----------------------------------------------------------------------------
// chord_envelope
//
// ADSR amplitude envelope applied to a chord sample stream. The envelope
// advances only on sample ticks (new_sample_ready). On each tick the incoming
// signed sample is scaled by the new envelope level. The scaled sample and a
// one-cycle valid pulse appear in the cycle after the tick.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   asynchronous active-low reset
//   new_sample_ready in   one-cycle sample-tick strobe
//   note_active      in   gate: 1 = note held, 0 = note released
//   sample_in        in   [15:0] signed chord sample, valid on tick cycles
//   sample_out       out  [15:0] signed enveloped sample (registered)
//   sample_valid     out  one-cycle pulse in the cycle after each tick
//   env_level        out  [7:0] registered envelope level
//   env_busy         out  1 whenever the envelope state is not IDLE
// -----------------------------------------------------------------------------
module chord_envelope #(
    parameter int ATTACK_STEP   = 16,
    parameter int DECAY_STEP    = 4,
    parameter int SUSTAIN_LEVEL = 192,
    parameter int RELEASE_STEP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic        note_active,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic [7:0]  env_level,
    output logic        env_busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam logic [8:0] ATK_9 = 9'(ATTACK_STEP);
    localparam logic [7:0] DEC_8 = 8'(DECAY_STEP);
    localparam logic [7:0] SUS_8 = 8'(SUSTAIN_LEVEL);
    localparam logic [7:0] REL_8 = 8'(RELEASE_STEP);
    // Any decay step from a level at or below this lands on (or below) the
    // sustain level, so the level is clamped there instead of underflowing.
    localparam logic [8:0] DEC_FLOOR_9 = {1'b0, SUS_8} + {1'b0, DEC_8};

    env_state_t         state_q, state_d;
    logic [7:0]         level_q, level_d;
    logic [15:0]        sample_out_q, sample_out_d;
    logic               sample_valid_q, sample_valid_d;

    logic [8:0]         sum_9;
    logic signed [23:0] sin_ext;
    logic signed [23:0] lvl_ext;
    logic signed [23:0] prod;

    // Next-state, next-level and output computation; everything holds off-tick.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        sum_9          = {1'b0, level_q} + ATK_9;
        sin_ext        = 24'sd0;
        lvl_ext        = 24'sd0;
        prod           = 24'sd0;

        if (new_sample_ready) begin
            case (state_q)
                ST_IDLE: begin
                    // Level stays 0 on the tick that enters ATTACK.
                    level_d = 8'd0;
                    if (note_active) begin
                        state_d = ST_ATTACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (!note_active) begin
                        state_d = ST_RELEASE;
                    end else if (sum_9 >= 9'd255) begin
                        level_d = 8'd255;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = sum_9[7:0];
                    end
                end
                ST_DECAY: begin
                    if (!note_active) begin
                        state_d = ST_RELEASE;
                    end else if ({1'b0, level_q} <= DEC_FLOOR_9) begin
                        level_d = SUS_8;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = level_q - DEC_8;
                    end
                end
                ST_SUSTAIN: begin
                    if (!note_active) begin
                        state_d = ST_RELEASE;
                    end else begin
                        level_d = SUS_8;
                    end
                end
                ST_RELEASE: begin
                    // Retrigger keeps the current level to avoid a click.
                    if (note_active) begin
                        state_d = ST_ATTACK;
                    end else if (level_q <= REL_8) begin
                        level_d = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q - REL_8;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = 8'd0;
                end
            endcase

            // Level is unsigned, so it is zero-extended before the signed multiply.
            sin_ext        = {{8{sample_in[15]}}, sample_in};
            lvl_ext        = {16'd0, level_d};
            prod           = sin_ext * lvl_ext;
            sample_out_d   = 16'(prod >>> 8);
            sample_valid_d = 1'b1;
        end else begin
            sample_valid_d = 1'b0;
        end
    end

    // State, level and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            level_q        <= 8'd0;
            sample_out_q   <= 16'd0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign env_level    = level_q;
    assign env_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_chord_envelope.sv
module tb_chord_envelope;

    localparam int ATK = 16;
    localparam int DEC = 4;
    localparam int SUS = 192;
    localparam int REL = 8;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic        note_active;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [7:0]  env_level;
    logic        env_busy;

    typedef struct {
        int out;
        int lvl;
        int busy;
    } exp_t;

    exp_t sb[$];

    int n_vec;
    int n_bad;

    // reference model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    int m_state;
    int m_level;
    int m_out;

    chord_envelope #(
        .ATTACK_STEP  (ATK),
        .DECAY_STEP   (DEC),
        .SUSTAIN_LEVEL(SUS),
        .RELEASE_STEP (REL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .new_sample_ready(new_sample_ready),
        .note_active     (note_active),
        .sample_in       (sample_in),
        .sample_out      (sample_out),
        .sample_valid    (sample_valid),
        .env_level       (env_level),
        .env_busy        (env_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_level = 0;
        m_out   = 0;
    endtask

    task automatic model_tick(input logic note, input int sin);
        case (m_state)
            0: begin
                m_level = 0;
                if (note) m_state = 1;
            end
            1: begin
                if (!note) m_state = 4;
                else begin
                    m_level = m_level + ATK;
                    if (m_level >= 255) begin
                        m_level = 255;
                        m_state = 2;
                    end
                end
            end
            2: begin
                if (!note) m_state = 4;
                else begin
                    m_level = m_level - DEC;
                    if (m_level <= SUS) begin
                        m_level = SUS;
                        m_state = 3;
                    end
                end
            end
            3: begin
                if (!note) m_state = 4;
                else m_level = SUS;
            end
            default: begin
                if (note) m_state = 1;
                else begin
                    m_level = m_level - REL;
                    if (m_level <= 0) begin
                        m_level = 0;
                        m_state = 0;
                    end
                end
            end
        endcase
        m_out = (sin * m_level) >>> 8;
    endtask

    // One sample tick: drive, push expectation, then pop and compare after the edge.
    task automatic do_tick(input logic note, input int sin);
        exp_t e;
        note_active      = note;
        sample_in        = 16'(sin);
        new_sample_ready = 1'b1;
        model_tick(note, sin);
        e.out  = m_out;
        e.lvl  = m_level;
        e.busy = (m_state != 0) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("sample_out", int'($signed(sample_out)), e.out);
            chk("env_level", int'(env_level), e.lvl);
            chk("env_busy", int'(env_busy), e.busy);
            chk("valid_tick", int'(sample_valid), 1);
        end
    endtask

    // Non-tick cycles: everything holds, valid drops.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("valid_idle", int'(sample_valid), 0);
            chk("hold_out", int'($signed(sample_out)), m_out);
            chk("hold_level", int'(env_level), m_level);
        end
    endtask

    initial begin
        n_vec            = 0;
        n_bad            = 0;
        reset            = 1'b0;
        new_sample_ready = 1'b0;
        note_active      = 1'b0;
        sample_in        = 16'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", int'(sample_out), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_level", int'(env_level), 0);
        chk("rst_busy", int'(env_busy), 0);
        reset = 1'b1;
        idle_cycles(2);

        // Attack: tick 1 enters ATTACK at level 0, ticks 2..17 ramp to 255
        do_tick(1'b1, 1000);
        chk("atk_t1_level", int'(env_level), 0);
        chk("atk_t1_out", int'($signed(sample_out)), 0);
        for (int t = 2; t <= 17; t++) begin
            do_tick(1'b1, 1000);
        end
        chk("atk_t17_level", int'(env_level), 255);

        // Decay: 16 ticks down to sustain
        for (int t = 1; t <= 16; t++) begin
            do_tick(1'b1, 1000);
            if (t == 1) chk("dec_t1_level", int'(env_level), 251);
        end
        chk("sus_level", int'(env_level), 192);
        chk("sus_out_pos", int'($signed(sample_out)), 750);
        do_tick(1'b1, -1000);
        chk("sus_out_neg", int'($signed(sample_out)), -750);

        // Hold / latency with long gaps, plus a gate pulse between ticks
        idle_cycles(20);
        note_active = 1'b0;
        idle_cycles(5);
        note_active = 1'b1;
        idle_cycles(25);
        do_tick(1'b1, 1234);
        chk("pulse_ignored_busy", int'(env_busy), 1);
        idle_cycles(3);

        // Release: hold tick, then 24 steps to 0, then idle silence
        do_tick(1'b0, 1000);
        chk("rel_hold_level", int'(env_level), 192);
        for (int t = 1; t <= 24; t++) begin
            do_tick(1'b0, 1000);
        end
        chk("rel_end_level", int'(env_level), 0);
        chk("rel_end_busy", int'(env_busy), 0);
        for (int t = 0; t < 3; t++) begin
            do_tick(1'b0, -30000);
            chk("idle_silent", int'($signed(sample_out)), 0);
        end

        // Retrigger from release at level 96
        for (int t = 0; t < 40 && m_state != 3; t++) begin
            do_tick(1'b1, 500);
        end
        chk("back_in_sustain", m_state, 3);
        do_tick(1'b0, 500);
        for (int t = 1; t <= 12; t++) begin
            do_tick(1'b0, 500);
        end
        chk("rel_at_96", int'(env_level), 96);
        do_tick(1'b1, 500);
        chk("retrig_level", int'(env_level), 96);
        chk("retrig_busy", int'(env_busy), 1);
        do_tick(1'b1, 500);
        chk("retrig_step", int'(env_level), 112);

        // Async reset mid-decay, not clock aligned
        for (int t = 0; t < 20 && m_state != 2; t++) begin
            do_tick(1'b1, -2000);
        end
        do_tick(1'b1, -2000);
        chk("in_decay", m_state, 2);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_out", int'(sample_out), 0);
        chk("arst_valid", int'(sample_valid), 0);
        chk("arst_level", int'(env_level), 0);
        chk("arst_busy", int'(env_busy), 0);
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_tick(1'b0, 1000);
        chk("post_rst_idle", int'(env_busy), 0);
        do_tick(1'b1, 1000);
        chk("post_rst_attack_lvl", int'(env_level), 0);
        do_tick(1'b1, 1000);
        chk("post_rst_step", int'(env_level), 16);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
